// File: rtl/popcount_sequencer.sv
// Multi-cycle population count: captures one wide word, then counts it
// CHUNK_WIDTH bits per cycle through a single narrow PopCounter.

module PopCounter #(
  parameter int WIDTH = 32,
  parameter int OUT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_data,
  output logic [OUT_W-1:0] o_count
);

  always_comb begin
    o_count = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      o_count = o_count + OUT_W'(i_data[i]);
    end
  end

endmodule

module popcount_sequencer #(
  parameter int DATA_WIDTH  = 256,
  parameter int CHUNK_WIDTH = 32
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_valid,
  output logic                            o_ready,
  input  logic [DATA_WIDTH-1:0]           i_data,
  input  logic                            i_flush,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic [$clog2(DATA_WIDTH+1)-1:0] o_data,
  output logic                            o_busy
);

  localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
  localparam int CNT_W      = $clog2(DATA_WIDTH + 1);
  localparam int PC_W       = $clog2(CHUNK_WIDTH + 1);
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  if ((DATA_WIDTH % CHUNK_WIDTH) != 0 || CHUNK_WIDTH <= 0) begin : g_width_check
    $error("popcount_sequencer: DATA_WIDTH must be a multiple of CHUNK_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state, state_nxt;
  logic [DATA_WIDTH-1:0]  word;
  logic [CNT_W-1:0]       acc;
  logic [CNT_W-1:0]       sum;
  logic [IDX_W-1:0]       idx;
  logic [CHUNK_WIDTH-1:0] chunk;
  logic [PC_W-1:0]        chunk_cnt;
  logic                   accept;
  logic                   last;

  assign chunk  = word[idx*CHUNK_WIDTH +: CHUNK_WIDTH];
  assign sum    = acc + CNT_W'(chunk_cnt);
  assign last   = (idx == LAST_IDX);
  // Flush outranks a new word arriving in IDLE.
  assign accept = (state == IDLE) && i_valid && !i_flush;

  PopCounter #(.WIDTH(CHUNK_WIDTH), .OUT_W(PC_W)) u_pop (
    .i_data  (chunk),
    .o_count (chunk_cnt)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (i_flush) state_nxt = IDLE;
               else if (last) state_nxt = DONE;
      DONE:    if (i_flush || i_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      word   <= '0;
      acc    <= '0;
      idx    <= '0;
      o_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            word <= i_data;
            acc  <= '0;
            idx  <= '0;
          end
        end
        RUN: begin
          if (i_flush) begin
            acc <= '0;
            idx <= '0;
          end else if (last) begin
            o_data <= sum;
            acc    <= sum;
            idx    <= '0;
          end else begin
            acc <= sum;
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (i_flush) begin
            acc <= '0;
            idx <= '0;
          end
        end
        default: begin
          acc <= '0;
          idx <= '0;
        end
      endcase
    end
  end

  assign o_ready = (state == IDLE);
  assign o_valid = (state == DONE);
  assign o_busy  = (state != IDLE);

endmodule

// File: tb/tb_popcount_sequencer.sv
// Bench for popcount_sequencer: directed corner cases plus random words
// checked against $countones and cycle-count timing expectations.

module tb_popcount_sequencer;

  localparam int DW    = 256;
  localparam int CW    = 32;
  localparam int N     = DW / CW;
  localparam int CNT_W = $clog2(DW + 1);

  logic             i_clk   = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_valid = 1'b0;
  logic             i_flush = 1'b0;
  logic             i_ready = 1'b0;
  logic [DW-1:0]    i_data  = '0;
  logic             o_ready;
  logic             o_valid;
  logic             o_busy;
  logic [CNT_W-1:0] o_data;

  int vectors     = 0;
  int miscompares = 0;

  popcount_sequencer #(.DATA_WIDTH(DW), .CHUNK_WIDTH(CW)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .i_flush (i_flush),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_busy  (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] r;
    for (int i = 0; i < N; i++) r[i*CW +: CW] = $urandom;
    return r;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(o_valid), 0);
    check({tag, "_ready"}, 32'(o_ready), 1);
    check({tag, "_busy"},  32'(o_busy),  0);
  endtask

  // One transaction starting from IDLE at a negedge. flush_at = k (1..N)
  // flushes during the k-th RUN cycle, N+1 flushes in DONE, -1 means none.
  task automatic do_word(input logic [DW-1:0] w, input int stall, input int flush_at);
    int unsigned exp;
    exp = $countones(w);
    check("accept_ready", 32'(o_ready), 1);
    i_valid = 1'b1;
    i_data  = w;
    i_flush = 1'b0;
    i_ready = 1'($urandom % 2);
    step();
    i_data = rand_word();
    for (int k = 1; k <= N; k++) begin
      check("run_valid", 32'(o_valid), 0);
      check("run_busy",  32'(o_busy),  1);
      check("run_ready", 32'(o_ready), 0);
      i_valid = 1'($urandom % 2);
      i_ready = 1'($urandom % 2);
      if (flush_at == k) begin
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        i_valid = 1'b0;
        check_idle("flush_run");
        return;
      end
      step();
    end
    i_valid = 1'b0;
    for (int s = 0; s < stall; s++) begin
      check("stall_valid", 32'(o_valid), 1);
      check("stall_data",  32'(o_data),  exp);
      check("stall_ready", 32'(o_ready), 0);
      i_ready = 1'b0;
      i_valid = 1'($urandom % 2);
      step();
    end
    check("done_valid", 32'(o_valid), 1);
    check("done_data",  32'(o_data),  exp);
    if (flush_at == N + 1) begin
      i_flush = 1'b1;
      i_ready = 1'($urandom % 2);
      i_valid = 1'b1;
      step();
      i_flush = 1'b0;
      i_valid = 1'b0;
      i_ready = 1'b0;
      check_idle("flush_done");
      return;
    end
    i_ready = 1'b1;
    i_valid = 1'b1;
    step();
    i_ready = 1'b0;
    i_valid = 1'b0;
    check_idle("release");
    check("held_data", 32'(o_data), exp);
  endtask

  initial begin
    logic [DW-1:0] w;
    int            stall;
    int            fl;

    repeat (2) @(negedge i_clk);
    check_idle("reset");
    check("reset_data", 32'(o_data), 0);
    i_rst_n = 1'b1;
    step();

    do_word('1, 0, -1);
    check("all_ones", 32'(o_data), 256);
    do_word('0, 0, -1);
    check("all_zero", 32'(o_data), 0);
    do_word({8{32'h5555_5555}}, 0, -1);
    check("alt_bits", 32'(o_data), 128);

    w = '0;
    w[0]      = 1'b1;
    w[DW-1]   = 1'b1;
    do_word(w, 0, -1);
    check("end_bits", 32'(o_data), 2);

    w = '0;
    w[3*CW +: CW] = 32'hFFFF_FFFF;
    do_word(w, 5, -1);
    check("chunk3", 32'(o_data), 32);

    do_word('1, 0, 4);
    w = '0;
    w[CW-1:0] = 32'hFFFF_FFFF;
    do_word(w, 0, -1);
    check("after_flush", 32'(o_data), 32);

    i_valid = 1'b1;
    i_flush = 1'b1;
    i_data  = '1;
    step();
    i_valid = 1'b0;
    i_flush = 1'b0;
    check_idle("idle_flush_prio");

    i_valid = 1'b1;
    i_data  = '1;
    step();
    i_valid = 1'b0;
    step();
    step();
    #2 i_rst_n = 1'b0;
    #1;
    check_idle("async_reset");
    check("async_reset_data", 32'(o_data), 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    w = rand_word();
    do_word(w, 1, -1);
    check("recovery", 32'(o_data), $countones(w));

    for (int t = 0; t < 5000; t++) begin
      w = rand_word();
      if ($urandom % 4 == 0) w = w & rand_word();
      stall = int'($urandom_range(0, 3));
      fl    = ($urandom % 8 == 0) ? int'($urandom_range(1, N + 1)) : -1;
      do_word(w, stall, fl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
